// File: rtl/reg_file.sv
// Architectural register file with per-register ROB rename tags and operand lookup.
// Optional REGFILE_BYPASS_EN: same-cycle commit value forwarded to operand reads.
module reg_file #(
    parameter int unsigned ROB_WIDTH_BIT = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     clear,
    input  logic [4:0]               commit_reg_id,
    input  logic [31:0]              commit_val,
    input  logic [ROB_WIDTH_BIT-1:0] commit_rob_id,
    input  logic [4:0]               rename_reg_id,
    input  logic [ROB_WIDTH_BIT-1:0] rename_rob_id,
    input  logic [4:0]               rs1_reg,
    input  logic [4:0]               rs2_reg,
    output logic [ROB_WIDTH_BIT-1:0] rob_rs1_id,
    output logic [ROB_WIDTH_BIT-1:0] rob_rs2_id,
    input  logic                     rob_rs1_ready,
    input  logic                     rob_rs2_ready,
    input  logic [31:0]              rob_rs1_val,
    input  logic [31:0]              rob_rs2_val,
    output logic                     rs1_dep,
    output logic                     rs2_dep,
    output logic [31:0]              rs1_val,
    output logic [31:0]              rs2_val,
    output logic [ROB_WIDTH_BIT-1:0] rs1_tag,
    output logic [ROB_WIDTH_BIT-1:0] rs2_tag
);

    logic [31:0]              value_q [32];
    logic [31:0]              busy_q;
    logic [ROB_WIDTH_BIT-1:0] tag_q   [32];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_q <= '0;
            for (int i = 0; i < 32; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
        end else if (rdy_in) begin
            if (commit_reg_id != 5'd0) begin
                value_q[commit_reg_id] <= commit_val;
                if (busy_q[commit_reg_id] && tag_q[commit_reg_id] == commit_rob_id) begin
                    busy_q[commit_reg_id] <= 1'b0;
                end
            end
            // Later assignments override the commit's busy release above.
            if (clear) begin
                busy_q <= '0;
                for (int i = 0; i < 32; i++) begin
                    tag_q[i] <= '0;
                end
            end else if (rename_reg_id != 5'd0) begin
                busy_q[rename_reg_id] <= 1'b1;
                tag_q[rename_reg_id]  <= rename_rob_id;
            end
        end
    end

    logic bypass1, bypass2;

`ifdef REGFILE_BYPASS_EN
    assign bypass1 = (rs1_reg != 5'd0) && (commit_reg_id == rs1_reg)
                     && (commit_rob_id == tag_q[rs1_reg]);
    assign bypass2 = (rs2_reg != 5'd0) && (commit_reg_id == rs2_reg)
                     && (commit_rob_id == tag_q[rs2_reg]);
`else
    assign bypass1 = 1'b0;
    assign bypass2 = 1'b0;
`endif

    always_comb begin
        rob_rs1_id = tag_q[rs1_reg];
        rs1_tag    = tag_q[rs1_reg];
        rs1_dep    = 1'b0;
        rs1_val    = value_q[rs1_reg];
        if (busy_q[rs1_reg]) begin
            if (bypass1) begin
                rs1_val = commit_val;
            end else if (rob_rs1_ready) begin
                rs1_val = rob_rs1_val;
            end else begin
                rs1_dep = 1'b1;
                rs1_val = '0;
            end
        end
    end

    always_comb begin
        rob_rs2_id = tag_q[rs2_reg];
        rs2_tag    = tag_q[rs2_reg];
        rs2_dep    = 1'b0;
        rs2_val    = value_q[rs2_reg];
        if (busy_q[rs2_reg]) begin
            if (bypass2) begin
                rs2_val = commit_val;
            end else if (rob_rs2_ready) begin
                rs2_val = rob_rs2_val;
            end else begin
                rs2_dep = 1'b1;
                rs2_val = '0;
            end
        end
    end

endmodule
